pipe_hazard_ctrl: RTL

//  Sequencing controller for the 5-stage RV32 pipeline. Decodes the IF/ID instruction and keeps a

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_instr_decode.sv | 63 ++++++
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared opcode and FSM encodings for the RV32 pipeline sequencing logic,
// plus the scoreboard source-match helper.
package pipe_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_MWAIT = 2'd2
    } state_e;

    // True when a valid scoreboard slot writes a register the ID instruction actually reads.
    function automatic logic src_hit(input logic       slot_v,
                                     input logic [4:0] slot_rd,
                                     input logic       use_rs1,
                                     input logic [4:0] rs1,
                                     input logic       use_rs2,
                                     input logic [4:0] rs2);
        return slot_v && ((use_rs1 && (rs1 == slot_rd)) || (use_rs2 && (rs2 == slot_rd)));
    endfunction

endpackage

// File: rtl/pipe_instr_decode.sv
// Combinational IF/ID decode: register fields and read/write usage flags.
// x0 is folded into the flags, so a zero source or destination never matches.
module pipe_instr_decode
    import pipe_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        writes_rd,
    output logic        is_load,
    output logic        is_br
);

    logic [6:0] opcode;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign rd                = instr[11:7];
    assign rs1               = instr[19:15];
    assign rs2               = instr[24:20];
    assign unused_instr_bits = ^{instr[31:25], instr[14:12]};

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        is_br     = 1'b0;
        case (opcode)
            OP_LW: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
                is_load   = 1'b1;
            end
            OP_ADDI: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
            end
            OP_R: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OP_SW: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_BEQ: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                is_br    = 1'b1;
            end
            default: ;
        endcase
        if (rd == 5'd0)  writes_rd = 1'b0;
        if (rs1 == 5'd0) uses_rs1  = 1'b0;
        if (rs2 == 5'd0) uses_rs2  = 1'b0;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: start-up, load-use/branch-operand stalls, taken-branch
// flush and data-memory wait. Build option PIPE_FWD_EN selects the forwarding-aware hazard set.
//
//  state    | meaning
//  ---------+-------------------------------------------------
//  ST_IDLE  | core not started, all enables low
//  ST_RUN   | pipeline advancing, stalling or flushing
//  ST_MWAIT | data memory busy, whole pipeline frozen
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      instr_i,
    input  logic             branch_taken_i,
    input  logic             dmem_busy_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             back_we_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    state_e state_q, state_d;

    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       dec_uses_rs1, dec_uses_rs2, dec_writes_rd, dec_is_load, dec_is_br;

    logic       ex_v_q, ex_load_q, mem_v_q, mem_load_q;
    logic [4:0] ex_rd_q, mem_rd_q;
    logic       ex_hit, mem_hit, stall;
    logic       sb_adv, cnt_inc;
    logic [CNT_W-1:0] stall_cnt_q;

    pipe_instr_decode u_decode (
        .instr     (instr_i),
        .rs1       (dec_rs1),
        .rs2       (dec_rs2),
        .rd        (dec_rd),
        .uses_rs1  (dec_uses_rs1),
        .uses_rs2  (dec_uses_rs2),
        .writes_rd (dec_writes_rd),
        .is_load   (dec_is_load),
        .is_br     (dec_is_br)
    );

    assign ex_hit  = src_hit(ex_v_q, ex_rd_q, dec_uses_rs1, dec_rs1, dec_uses_rs2, dec_rs2);
    assign mem_hit = src_hit(mem_v_q, mem_rd_q, dec_uses_rs1, dec_rs1, dec_uses_rs2, dec_rs2);

`ifdef PIPE_FWD_EN
    // Only a load in EX, or a branch comparing in ID before the value reaches a forward path.
    assign stall = (ex_hit & ex_load_q) | (dec_is_br & (ex_hit | (mem_hit & mem_load_q)));
`else
    logic unused_mem_load;
    assign unused_mem_load = mem_load_q;
    assign stall = ex_hit | mem_hit;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        pc_we_o       = 1'b0;
        ifid_we_o     = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        back_we_o     = 1'b0;
        sb_adv        = 1'b0;
        cnt_inc       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (dmem_busy_i) begin
                    state_d = ST_MWAIT;
                    cnt_inc = 1'b1;
                end else if (stall) begin
                    idex_bubble_o = 1'b1;
                    back_we_o     = 1'b1;
                    sb_adv        = 1'b1;
                    cnt_inc       = 1'b1;
                end else begin
                    pc_we_o      = 1'b1;
                    ifid_we_o    = 1'b1;
                    back_we_o    = 1'b1;
                    ifid_flush_o = dec_is_br & branch_taken_i;
                    sb_adv       = 1'b1;
                end
            end
            ST_MWAIT: begin
                cnt_inc = 1'b1;
                if (!dmem_busy_i) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow of the EX and MEM destination registers; a bubble enters EX as empty.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_v_q     <= 1'b0;
            ex_rd_q    <= '0;
            ex_load_q  <= 1'b0;
            mem_v_q    <= 1'b0;
            mem_rd_q   <= '0;
            mem_load_q <= 1'b0;
        end else if (sb_adv) begin
            mem_v_q    <= ex_v_q;
            mem_rd_q   <= ex_rd_q;
            mem_load_q <= ex_load_q;
            ex_v_q     <= dec_writes_rd & ~idex_bubble_o;
            ex_rd_q    <= dec_rd;
            ex_load_q  <= dec_is_load & ~idex_bubble_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                               stall_cnt_q <= '0;
        else if (cnt_inc && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
